// File: rtl/gbdt_argmax_ctrl.sv
// Argmax sequencer: walks up to four 8-class score groups through the max_result comparator.
// Optional RUN watchdog: define GBDT_ARGMAX_TIMEOUT_EN.
module gbdt_argmax_ctrl #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        gbdt_clk,
    input  logic        gbdt_rst_n,
    input  logic        start,
    input  logic [1:0]  num_grp_m1,
    input  logic        flush,
    output logic        grp_req,
    output logic [1:0]  grp_idx,
    input  logic        grp_valid,
    output logic        grp_ack,
    output logic        max_enable,
    output logic [1:0]  round,
    output logic [31:0] old_max_result,
    output logic [4:0]  old_max_class,
    input  logic        max_done,
    input  logic [31:0] new_max_result,
    input  logic [4:0]  new_max_class,
    output logic        busy,
    output logic        done,
    output logic [4:0]  class_out,
    output logic [31:0] score_out,
    output logic        err
);

`ifdef GBDT_ARGMAX_TIMEOUT_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RUN, S_SETTLE, S_DONE, S_TOUT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RUN, S_SETTLE, S_DONE} state_t;
`endif

    state_t     state, next_state;
    logic [1:0] num_grp;
    logic       cmp_hit;

    assign round   = grp_idx;
    assign cmp_hit = (state == S_RUN) && max_done && !flush;

`ifdef GBDT_ARGMAX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    logic [CW-1:0] tmo_cnt;
    logic          tout_seen;
    logic          tmo_hit;

    assign tmo_hit = (int'(tmo_cnt) == TIMEOUT_CYC - 1);

    always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
        if (!gbdt_rst_n) begin
            tmo_cnt   <= '0;
            tout_seen <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (state != S_RUN) tmo_cnt <= '0;
            else                tmo_cnt <= tmo_cnt + 1'b1;
            // Remembers that the SETTLE in flight came from a timeout, so it exits to IDLE.
            if (next_state == S_TOUT)      tout_seen <= 1'b1;
            else if (next_state == S_IDLE) tout_seen <= 1'b0;
            err <= (next_state == S_TOUT);
        end
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign err = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = S_REQ;
            S_REQ:    if (grp_valid) next_state = S_RUN;
            S_RUN: begin
                if (max_done)
                    next_state = (grp_idx == num_grp) ? S_DONE : S_SETTLE;
`ifdef GBDT_ARGMAX_TIMEOUT_EN
                else if (tmo_hit)
                    next_state = S_TOUT;
`endif
            end
`ifdef GBDT_ARGMAX_TIMEOUT_EN
            S_SETTLE: next_state = tout_seen ? S_IDLE : S_REQ;
            S_TOUT:   next_state = S_SETTLE;
`else
            S_SETTLE: next_state = S_REQ;
`endif
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
        if (flush) next_state = S_IDLE;
    end

    // Every output is a flop loaded from the next-state decode.
    always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
        if (!gbdt_rst_n) begin
            state          <= S_IDLE;
            num_grp        <= '0;
            grp_idx        <= '0;
            grp_req        <= 1'b0;
            grp_ack        <= 1'b0;
            max_enable     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            old_max_result <= '0;
            old_max_class  <= '0;
            class_out      <= '0;
            score_out      <= '0;
        end else begin
            state      <= next_state;
            grp_req    <= (next_state == S_REQ);
            max_enable <= (next_state == S_RUN);
            busy       <= (next_state != S_IDLE);
            done       <= (next_state == S_DONE);
            grp_ack    <= cmp_hit;
            if (state == S_IDLE && start && !flush) begin
                num_grp        <= num_grp_m1;
                grp_idx        <= '0;
                old_max_result <= '0;
                old_max_class  <= '0;
            end
            if (cmp_hit) begin
                old_max_result <= new_max_result;
                old_max_class  <= new_max_class;
                if (next_state == S_SETTLE) grp_idx <= grp_idx + 2'd1;
                // Result goes straight from the comparator so it lines up with done.
                if (next_state == S_DONE) begin
                    class_out <= new_max_class;
                    score_out <= new_max_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_gbdt_argmax_ctrl.sv
// Bench for gbdt_argmax_ctrl: behavioural comparator and group source, scoreboard of expected winners.
module tb_gbdt_argmax_ctrl;

    logic        gbdt_clk = 1'b0;
    logic        gbdt_rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  num_grp_m1 = '0;
    logic        flush = 1'b0;
    logic        grp_req;
    logic [1:0]  grp_idx;
    logic        grp_valid = 1'b1;
    logic        grp_ack;
    logic        max_enable;
    logic [1:0]  round;
    logic [31:0] old_max_result;
    logic [4:0]  old_max_class;
    logic        max_done;
    logic [31:0] new_max_result;
    logic [4:0]  new_max_class;
    logic        busy;
    logic        done;
    logic [4:0]  class_out;
    logic [31:0] score_out;
    logic        err;

    gbdt_argmax_ctrl #(.TIMEOUT_CYC(16)) dut (
        .gbdt_clk(gbdt_clk), .gbdt_rst_n(gbdt_rst_n), .start(start), .num_grp_m1(num_grp_m1),
        .flush(flush), .grp_req(grp_req), .grp_idx(grp_idx), .grp_valid(grp_valid),
        .grp_ack(grp_ack), .max_enable(max_enable), .round(round),
        .old_max_result(old_max_result), .old_max_class(old_max_class), .max_done(max_done),
        .new_max_result(new_max_result), .new_max_class(new_max_class), .busy(busy),
        .done(done), .class_out(class_out), .score_out(score_out), .err(err)
    );

    always #5 gbdt_clk = ~gbdt_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Comparator model: done on 3rd cycle of enable, plus one trailing cycle.
    logic [31:0] scores [32];
    int          run_len;
    logic        trail;
    logic        stuck0 = 1'b0;

    always @(posedge gbdt_clk or negedge gbdt_rst_n) begin
        if (!gbdt_rst_n) begin
            run_len <= 0;
            trail   <= 1'b0;
        end else begin
            run_len <= max_enable ? run_len + 1 : 0;
            trail   <= max_enable && (run_len >= 2);
        end
    end

    assign max_done = !stuck0 && ((max_enable && run_len >= 2) || (!max_enable && trail));

    always_comb begin
        new_max_result = old_max_result;
        new_max_class  = old_max_class;
        for (int i = 0; i < 8; i++) begin
            if (scores[{round, 3'(i)}] > new_max_result) begin
                new_max_result = scores[{round, 3'(i)}];
                new_max_class  = {round, 3'(i)};
            end
        end
    end

    typedef struct {
        logic [4:0]  cls;
        logic [31:0] score;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    task automatic fill_rand(input logic [31:0] mask);
        for (int c = 0; c < 32; c++) scores[c] = $urandom & mask;
    endtask

    // One classification; flush_grp >= 0 aborts on the first RUN cycle of that group.
    task automatic run(input int ngrp, input int stall, input int flush_grp);
        exp_t        e;
        logic [31:0] best;
        logic [4:0]  bc;
        logic [7:0]  seq, exp_seq;
        logic [4:0]  prev_cls;
        logic [31:0] prev_sc;
        int          acks, stall_left, dcnt;
        bit          prev_en, fin, flushed;
        best = '0;
        bc   = '0;
        for (int c = 0; c < 8 * ngrp; c++)
            if (scores[c] > best) begin
                best = scores[c];
                bc   = 5'(c);
            end
        e.cls = bc;
        e.score = best;
        e.cyc = 5 * ngrp + stall;
        if (flush_grp < 0) sb.push_back(e);
        exp_seq = '0;
        for (int g = 0; g < ngrp; g++) exp_seq = {exp_seq[5:0], 2'(g)};
        seq = '0; acks = 0; prev_en = 0; fin = 0; flushed = 0; stall_left = stall;
        prev_cls = class_out; prev_sc = score_out;
        num_grp_m1 = 2'(ngrp - 1);
        grp_valid = 1'b1;
        start = 1'b1;
        for (int n = 1; n <= 200 && !fin; n++) begin
            @(posedge gbdt_clk); #1;
            start = 1'b0;
            if (flushed) begin
                flush = 1'b0;
                chk("flush_ctl", {busy, max_enable, grp_req, grp_ack, done}, '0);
                chk("flush_keep", {class_out, score_out}, {prev_cls, prev_sc});
                dcnt = 0;
                for (int k = 0; k < 8; k++) begin
                    @(posedge gbdt_clk); #1;
                    if (done) dcnt++;
                end
                chk("flush_nodone", dcnt, 0);
                fin = 1;
            end else begin
                if (grp_ack) acks++;
                if (max_enable && !prev_en) seq = {seq[5:0], round};
                prev_en = max_enable;
                if (done) begin
                    if (sb.size() == 0) chk("unexpected_done", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("class_out", class_out, e.cls);
                        chk("score_out", score_out, e.score);
                        chk("done_cycle", n, e.cyc);
                        chk("ack_count", acks, ngrp);
                        chk("round_seq", seq, exp_seq);
                    end
                    fin = 1;
                end else if (flush_grp >= 0 && max_enable && round == 2'(flush_grp)) begin
                    flush = 1'b1;
                    flushed = 1;
                end
                if (grp_req && stall_left > 0) begin
                    grp_valid = 1'b0;
                    stall_left--;
                end else grp_valid = 1'b1;
            end
        end
        if (!fin) chk("done_timeout", 0, 1);
        grp_valid = 1'b1;
        @(posedge gbdt_clk); #1;
    endtask

    initial begin
        for (int c = 0; c < 32; c++) scores[c] = '0;
        repeat (2) @(posedge gbdt_clk);
        #1;
        chk("rst_ctl", {busy, done, grp_req, grp_ack, max_enable, err, grp_idx, round}, '0);
        chk("rst_max", {old_max_class, old_max_result}, '0);
        chk("rst_out", {class_out, score_out}, '0);
        gbdt_rst_n = 1'b1;
        @(posedge gbdt_clk); #1;

        // Tie on 9 resolves to the lower index
        scores[0] = 5; scores[1] = 9; scores[2] = 3; scores[3] = 9;
        scores[4] = 0; scores[5] = 1; scores[6] = 2; scores[7] = 8;
        run(1, 0, -1);

        fill_rand(32'h7FFF_FFFF);
        scores[19] = 32'hFFFF_0000;
        run(4, 0, -1);

        for (int c = 0; c < 32; c++) scores[c] = '0;
        run(2, 0, -1);
        run(2, 3, -1);

        fill_rand(32'hFFFF_FFFF);
        run(2, 0, 1);
        run(3, 0, -1);

        // Asynchronous reset in the middle of RUN
        fill_rand(32'h0000_FFFF);
        num_grp_m1 = 2'd0;
        start = 1'b1;
        for (int n = 0; n < 10 && !max_enable; n++) begin
            @(posedge gbdt_clk); #1;
            start = 1'b0;
        end
        chk("rst_run_pre", max_enable, 1);
        #2 gbdt_rst_n = 1'b0;
        #1;
        chk("rst_run_ctl", {busy, done, grp_req, grp_ack, max_enable, err, grp_idx, round}, '0);
        chk("rst_run_max", {old_max_class, old_max_result}, '0);
        chk("rst_run_out", {class_out, score_out}, '0);
        @(posedge gbdt_clk); #1;
        gbdt_rst_n = 1'b1;
        @(posedge gbdt_clk); #1;
        run(1, 0, -1);

`ifdef GBDT_ARGMAX_TIMEOUT_EN
        begin
            int          n_err, busy_at, dcnt;
            logic [4:0]  keep_cls;
            keep_cls = class_out;
            n_err = -1; busy_at = 1; dcnt = 0;
            stuck0 = 1'b1;
            num_grp_m1 = 2'd0;
            start = 1'b1;
            for (int n = 1; n <= 30; n++) begin
                @(posedge gbdt_clk); #1;
                start = 1'b0;
                if (err && n_err < 0) n_err = n;
                if (done) dcnt++;
                if (n_err >= 0 && n == n_err + 2) busy_at = busy;
            end
            stuck0 = 1'b0;
            chk("tout_err_cycle", n_err, 18);
            chk("tout_busy", busy_at, 0);
            chk("tout_nodone", dcnt, 0);
            chk("tout_keep", class_out, keep_cls);
        end
`endif

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
